// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller and the datapath pipeline registers:
// FSM state encoding, stall/flush bit-vector ordering and the load-use detector.
package hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // Stall vector bit order, shared with the pipeline-register instances.
    localparam int STALL_W      = 4;
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;

    // Flush vector bit order.
    localparam int FLUSH_W      = 2;
    localparam int FLUSH_IF_ID  = 0;
    localparam int FLUSH_ID_EX  = 1;

    // A load in EX whose destination is read by the ID instruction; x0 is never a hazard.
    function automatic logic lduse_detect(
        input logic [4:0] ra0,
        input logic [4:0] ra1,
        input logic       re0,
        input logic       re1,
        input logic       mem_re,
        input logic       we,
        input logic [4:0] wa
    );
        lduse_detect = mem_re & we & (wa != 5'd0) &
                       ((re0 & (ra0 == wa)) | (re1 & (ra1 == wa)));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters: three free-running, wrapping counters with increment enables.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc_lduse,
    input  logic             inc_memwait,
    input  logic             inc_flush,
    output logic [CNT_W-1:0] cnt_lduse,
    output logic [CNT_W-1:0] cnt_memwait,
    output logic [CNT_W-1:0] cnt_flush
);

    // Each counter advances by one when its enable is high and wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_lduse   <= '0;
            cnt_memwait <= '0;
            cnt_flush   <= '0;
        end else begin
            if (inc_lduse)   cnt_lduse   <= cnt_lduse   + CNT_W'(1);
            if (inc_memwait) cnt_memwait <= cnt_memwait + CNT_W'(1);
            if (inc_flush)   cnt_flush   <= cnt_flush   + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage LA32R pipeline: resolves load-use, EX redirects and
// multi-cycle data-memory accesses into stall/flush controls, and tracks hazard statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rf_ra0_id,
    input  logic [4:0]       rf_ra1_id,
    input  logic             rf_re0_id,
    input  logic             rf_re1_id,
    input  logic             mem_re_ex,
    input  logic             rf_we_ex,
    input  logic [4:0]       rf_wa_ex,
    input  logic             br_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_lduse,
    output logic [CNT_W-1:0] cnt_memwait,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    hz_state_t           state;
    hz_state_t           state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                lduse;
    logic                memhold;
    logic                apply_run;
    logic [STALL_W-1:0]  stall_vec;
    logic [FLUSH_W-1:0]  flush_vec;
    logic                inc_lduse;
    logic                inc_memwait;
    logic                inc_flush;

    assign lduse   = lduse_detect(rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id,
                                  mem_re_ex, rf_we_ex, rf_wa_ex);
    assign memhold = dmem_req_mem & ~dmem_ready;

    // State register plus the wait-length tracker and the sticky timeout flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (memhold && (wait_nxt == WAIT_MAX)) mem_timeout <= 1'b1;
        end
    end

    // Next state: enter the wait on an unfinished access, leave it once the access completes or
    // the request is withdrawn. The wait count includes the entry cycle and saturates.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            ST_RUN: begin
                if (memhold) begin
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = WAIT_ONE;
                end else begin
                    wait_nxt  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (memhold) begin
                    wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_ONE;
                end else begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Outputs: freeze the whole front end while memory is busy; otherwise a redirect squashes
    // IF/ID and ID/EX (overriding load-use, whose ID instruction dies anyway), and a load-use
    // holds PC and IF/ID while injecting a bubble into ID/EX. The release cycle of a wait uses
    // the same rules, so a redirect frozen in EX fires there. Forced quiet while in reset.
    always_comb begin
        stall_vec   = '0;
        flush_vec   = '0;
        inc_lduse   = 1'b0;
        inc_memwait = 1'b0;
        inc_flush   = 1'b0;
        apply_run   = 1'b0;
        case (state)
            ST_RUN: begin
                if (memhold) stall_vec = '1;
                else         apply_run = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (memhold) begin
                    stall_vec   = '1;
                    inc_memwait = 1'b1;
                end else begin
                    apply_run   = 1'b1;
                end
            end
            default: apply_run = 1'b0;
        endcase
        if (apply_run) begin
            if (br_taken_ex) begin
                flush_vec = '1;
                inc_flush = 1'b1;
            end else if (lduse) begin
                stall_vec[STALL_PC]    = 1'b1;
                stall_vec[STALL_IF_ID] = 1'b1;
                flush_vec[FLUSH_ID_EX] = 1'b1;
                inc_lduse              = 1'b1;
            end
        end
        if (!rstn) begin
            stall_vec   = '0;
            flush_vec   = '0;
            inc_lduse   = 1'b0;
            inc_memwait = 1'b0;
            inc_flush   = 1'b0;
        end
    end

    assign stall_pc     = stall_vec[STALL_PC];
    assign stall_if_id  = stall_vec[STALL_IF_ID];
    assign stall_id_ex  = stall_vec[STALL_ID_EX];
    assign stall_ex_mem = stall_vec[STALL_EX_MEM];
    assign flush_if_id  = flush_vec[FLUSH_IF_ID];
    assign flush_id_ex  = flush_vec[FLUSH_ID_EX];

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .inc_lduse   (inc_lduse),
        .inc_memwait (inc_memwait),
        .inc_flush   (inc_flush),
        .cnt_lduse   (cnt_lduse),
        .cnt_memwait (cnt_memwait),
        .cnt_flush   (cnt_flush)
    );

endmodule
